// File: rtl/gcd_req_dispatch.sv
// gcd_req_dispatch: request front end for gcd_top.
// Buffers tagged signed operand pairs in a small FIFO, converts them to
// magnitudes, answers trivial cases (a zero operand, or an operand equal to
// the most negative value, which has no magnitude) locally, and hands all
// other pairs to the gcd core through a Start/Done handshake.
// Optional build macro: GCD_DISPATCH_TIMEOUT_EN adds a watchdog on the core
// that turns a stuck request into an error result after TIMEOUT_CYCLES.
module gcd_req_dispatch #(
  parameter int DATA_WIDTH     = 32,
  parameter int FIFO_DEPTH     = 4,
  parameter int TAG_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic                           InValid,
  output logic                           InReady,
  input  logic signed [DATA_WIDTH-1:0]   InA,
  input  logic signed [DATA_WIDTH-1:0]   InB,
  input  logic        [TAG_WIDTH-1:0]    InTag,
  output logic                           CoreStart,
  output logic        [DATA_WIDTH-1:0]   CoreA,
  output logic        [DATA_WIDTH-1:0]   CoreB,
  input  logic        [DATA_WIDTH-1:0]   CoreResult,
  input  logic                           CoreDone,
  output logic                           OutValid,
  input  logic                           OutReady,
  output logic        [DATA_WIDTH-1:0]   OutResult,
  output logic        [TAG_WIDTH-1:0]    OutTag,
  output logic                           OutErr,
  output logic [$clog2(FIFO_DEPTH):0]    FifoLevel
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  localparam logic signed [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  // Two's-complement magnitude; MIN_VAL is filtered out before use.
  function automatic logic [DATA_WIDTH-1:0] magnitude(input logic signed [DATA_WIDTH-1:0] v);
    logic signed [DATA_WIDTH-1:0] neg;
    neg = -v;
    return v[DATA_WIDTH-1] ? $unsigned(neg) : $unsigned(v);
  endfunction

  logic [1:0]                   state;
  logic signed [DATA_WIDTH-1:0] fifo_a [FIFO_DEPTH];
  logic signed [DATA_WIDTH-1:0] fifo_b [FIFO_DEPTH];
  logic [TAG_WIDTH-1:0]         fifo_tag [FIFO_DEPTH];
  logic [AW-1:0]                wr_ptr, rd_ptr;
  logic                         push, pop;

  logic signed [DATA_WIDTH-1:0] head_a, head_b;
  logic [DATA_WIDTH-1:0]        mag_a, mag_b, bypass_res;
  logic                         unrep, a_zero, b_zero, bypass;

  logic [TAG_WIDTH-1:0]         cur_tag;
  logic [DATA_WIDTH-1:0]        cap_res;
  logic                         cap_err;
  logic                         tmo_hit;

  assign InReady = Reset && (FifoLevel != LW'(FIFO_DEPTH));
  assign push    = InValid && InReady;
  assign pop     = (state == S_IDLE) && (FifoLevel != '0) && !CoreDone;

  assign head_a     = fifo_a[rd_ptr];
  assign head_b     = fifo_b[rd_ptr];
  assign mag_a      = magnitude(head_a);
  assign mag_b      = magnitude(head_b);
  assign unrep      = (head_a == MIN_VAL) || (head_b == MIN_VAL);
  assign a_zero     = (head_a == '0);
  assign b_zero     = (head_b == '0);
  assign bypass     = unrep || a_zero || b_zero;
  // A zero operand leaves the other magnitude as the gcd; both zero gives 0.
  assign bypass_res = unrep ? '0 : (a_zero ? mag_b : mag_a);

`ifdef GCD_DISPATCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;

  // Watchdog: counts RUN cycles, held at zero everywhere else.
  always_ff @(posedge Clk) begin
    if (!Reset || state != S_RUN) tmo_cnt <= '0;
    else                          tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign tmo_hit = (state == S_RUN) && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  // Without the watchdog the core is waited on indefinitely.
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign tmo_hit        = 1'b0;
`endif

  // FIFO pointers and occupancy.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      FifoLevel <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      FifoLevel <= FifoLevel + LW'(push) - LW'(pop);
    end
  end

  // Datapath storage: FIFO contents and the request held while the core runs.
  always_ff @(posedge Clk) begin
    if (push) begin
      fifo_a[wr_ptr]   <= InA;
      fifo_b[wr_ptr]   <= InB;
      fifo_tag[wr_ptr] <= InTag;
    end
    if (pop && !bypass) cur_tag <= fifo_tag[rd_ptr];
    if (state == S_RUN) begin
      if (CoreDone) begin
        cap_res <= CoreResult;
        cap_err <= 1'b0;
      end else if (tmo_hit) begin
        cap_res <= '0;
        cap_err <= 1'b1;
      end
    end
  end

  // Request sequencing: dispatch, wait for the core, wait for Done to clear, present.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state     <= S_IDLE;
      CoreStart <= 1'b0;
      CoreA     <= '0;
      CoreB     <= '0;
      OutValid  <= 1'b0;
      OutResult <= '0;
      OutTag    <= '0;
      OutErr    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            if (bypass) begin
              OutResult <= bypass_res;
              OutTag    <= fifo_tag[rd_ptr];
              OutErr    <= unrep;
              OutValid  <= 1'b1;
              state     <= S_OUT;
            end else begin
              CoreA     <= mag_a;
              CoreB     <= mag_b;
              CoreStart <= 1'b1;
              state     <= S_RUN;
            end
          end
        end
        S_RUN: begin
          // Done wins over a watchdog expiry on the same edge.
          if (CoreDone || tmo_hit) begin
            CoreStart <= 1'b0;
            state     <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Level-type Done must fall before the result is released.
          if (!CoreDone) begin
            OutResult <= cap_res;
            OutTag    <= cur_tag;
            OutErr    <= cap_err;
            OutValid  <= 1'b1;
            state     <= S_OUT;
          end
        end
        default: begin
          if (OutReady) begin
            OutValid <= 1'b0;
            state    <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_req_dispatch.sv
// Bench for gcd_req_dispatch: a behavioural gcd core responder with random
// latency and pulse/level Done, and a reference queue computed from the
// arithmetic meaning of each request.
module tb_gcd_req_dispatch;

  localparam int DW = 32;
  localparam int TGW = 4;

  logic                 Clk = 1'b0;
  logic                 Reset;
  logic                 InValid;
  logic                 InReady;
  logic signed [DW-1:0] InA, InB;
  logic [TGW-1:0]       InTag;
  logic                 CoreStart;
  logic [DW-1:0]        CoreA, CoreB;
  logic [DW-1:0]        CoreResult;
  logic                 CoreDone;
  logic                 OutValid;
  logic                 OutReady;
  logic [DW-1:0]        OutResult;
  logic [TGW-1:0]       OutTag;
  logic                 OutErr;
  logic [2:0]           FifoLevel;

  gcd_req_dispatch #(
    .DATA_WIDTH(DW), .FIFO_DEPTH(4), .TAG_WIDTH(TGW), .TIMEOUT_CYCLES(16)
  ) dut (
    .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .InA(InA), .InB(InB), .InTag(InTag),
    .CoreStart(CoreStart), .CoreA(CoreA), .CoreB(CoreB),
    .CoreResult(CoreResult), .CoreDone(CoreDone),
    .OutValid(OutValid), .OutReady(OutReady), .OutResult(OutResult),
    .OutTag(OutTag), .OutErr(OutErr), .FifoLevel(FifoLevel)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [DW-1:0]  res;
    logic [TGW-1:0] tag;
    logic           err;
  } exp_t;

  exp_t model_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Core responder state
  logic          core_auto = 1'b1;
  logic          done_auto, done_man;
  logic [DW-1:0] res_auto, res_man;
  logic          core_busy, prev_start;
  int            core_wait, core_hold, start_cnt;
  logic [DW-1:0] op_a, op_b, last_a, last_b;

  assign CoreDone   = core_auto ? done_auto : done_man;
  assign CoreResult = core_auto ? res_auto  : res_man;

  function automatic logic [DW-1:0] core_gcd(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] x, y, r;
    x = a; y = b;
    while (y != 0) begin r = x % y; x = y; y = r; end
    return x;
  endfunction

  // What the block should report for a request, from arithmetic alone.
  function automatic exp_t ref_model(input longint a, input longint b, input logic [TGW-1:0] t);
    exp_t   e;
    longint x, y, r;
    e.tag = t; e.err = 1'b0; e.res = '0;
    if (a == -64'sd2147483648 || b == -64'sd2147483648) begin
      e.err = 1'b1;
      return e;
    end
    x = (a < 0) ? -a : a;
    y = (b < 0) ? -b : b;
    while (y != 0) begin r = x % y; x = y; y = r; end
    e.res = x[DW-1:0];
    return e;
  endfunction

  function automatic logic signed [DW-1:0] rand_op();
    int unsigned sel;
    int          v;
    sel = $urandom_range(0, 9);
    if (sel == 0) return '0;
    if (sel == 1) return 32'sh8000_0000;
    if (sel == 2) return 32'sh7fff_ffff;
    v = $urandom_range(1, 5000) * $urandom_range(1, 12);
    return ($urandom_range(0, 1) == 1) ? -v : v;
  endfunction

  // gcd core stand-in: random latency, Done either a one-cycle pulse or held a few cycles
  initial begin
    core_busy = 0; done_auto = 0; res_auto = '0; prev_start = 0; start_cnt = 0;
    core_wait = 0; core_hold = 0; last_a = '0; last_b = '0; op_a = '0; op_b = '0;
    forever begin
      @(negedge Clk);
      if (CoreStart === 1'b1 && !prev_start) begin
        start_cnt++;
        last_a = CoreA;
        last_b = CoreB;
      end
      prev_start = (CoreStart === 1'b1);
      if (!core_auto) begin
        core_busy = 0;
        done_auto = 0;
      end else if (!core_busy) begin
        if (CoreStart === 1'b1) begin
          core_busy = 1;
          core_wait = $urandom_range(0, 5);
          op_a = CoreA;
          op_b = CoreB;
        end
      end else if (!done_auto) begin
        if (core_wait == 0) begin
          done_auto = 1;
          res_auto  = core_gcd(op_a, op_b);
          core_hold = $urandom_range(0, 3);
        end else core_wait--;
      end else if (core_hold == 0) begin
        done_auto = 0;
        core_busy = 0;
      end else core_hold--;
    end
  end

  // Offer one request for one cycle; called at a falling edge, returns at the next.
  task automatic push_one(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b,
                          input logic [TGW-1:0] t, output bit acc);
    InValid = 1'b1; InA = a; InB = b; InTag = t;
    acc = (InReady === 1'b1);
    if (acc) model_q.push_back(ref_model(a, b, t));
    @(negedge Clk);
    InValid = 1'b0;
  endtask

  // Wait (bounded) for a result and accept it.
  task automatic collect(output logic [DW-1:0] r, output logic [TGW-1:0] tg,
                         output logic e, output bit ok);
    ok = 0; r = '0; tg = '0; e = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      if (OutValid === 1'b1) begin
        r = OutResult; tg = OutTag; e = OutErr; ok = 1;
        OutReady = 1'b1;
        @(negedge Clk);
        OutReady = 1'b0;
      end else @(negedge Clk);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b0; InValid = 1'b0; OutReady = 1'b0;
    InA = '0; InB = '0; InTag = '0; done_man = 1'b0; res_man = '0;
    @(negedge Clk);
    n_checks++;
    if (InReady !== 1'b0 || OutValid !== 1'b0 || CoreStart !== 1'b0 || FifoLevel !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl got InReady=%b OutValid=%b CoreStart=%b FifoLevel=%0d want 0 0 0 0",
               InReady, OutValid, CoreStart, FifoLevel);
    end
    n_checks++;
    if (CoreA !== '0 || CoreB !== '0 || OutResult !== '0 || OutTag !== '0 || OutErr !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_data got CoreA=%0d CoreB=%0d OutResult=%0d OutTag=%0d OutErr=%b want all 0",
               CoreA, CoreB, OutResult, OutTag, OutErr);
    end
    Reset = 1'b1;
    @(negedge Clk);
    n_checks++;
    if (InReady !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_inready got %b want 1", InReady);
    end
  endtask

  task automatic test_core_path(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b,
                                input logic [TGW-1:0] t, input logic [DW-1:0] want_ca,
                                input logic [DW-1:0] want_cb);
    bit acc, ok; logic [DW-1:0] r; logic [TGW-1:0] tg; logic e; int s0; exp_t x;
    s0 = start_cnt;
    push_one(a, b, t, acc);
    collect(r, tg, e, ok);
    x = model_q.pop_front();
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL core_timeout no OutValid for a=%0d b=%0d", a, b); end
    n_checks++;
    if (start_cnt - s0 !== 1) begin n_fail++; $display("FAIL core_starts got %0d want 1", start_cnt - s0); end
    n_checks++;
    if (last_a !== want_ca || last_b !== want_cb) begin
      n_fail++;
      $display("FAIL core_operands got CoreA=%0d CoreB=%0d want %0d %0d", last_a, last_b, want_ca, want_cb);
    end
    n_checks++;
    if (r !== x.res || tg !== x.tag || e !== x.err) begin
      n_fail++;
      $display("FAIL core_result got res=%0d tag=%0d err=%b want %0d %0d %b", r, tg, e, x.res, x.tag, x.err);
    end
  endtask

  task automatic test_bypass(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b,
                             input logic [TGW-1:0] t);
    bit acc; int s0; exp_t x;
    s0 = start_cnt;
    push_one(a, b, t, acc);
    x = model_q.pop_front();
    n_checks++;
    if (OutValid !== 1'b0) begin n_fail++; $display("FAIL bypass_early got OutValid=%b want 0", OutValid); end
    @(negedge Clk);
    n_checks++;
    if (OutValid !== 1'b1 || OutResult !== x.res || OutTag !== x.tag || OutErr !== x.err) begin
      n_fail++;
      $display("FAIL bypass_result got v=%b res=%0d tag=%0d err=%b want 1 %0d %0d %b",
               OutValid, OutResult, OutTag, OutErr, x.res, x.tag, x.err);
    end
    OutReady = 1'b1;
    @(negedge Clk);
    OutReady = 1'b0;
    n_checks++;
    if (start_cnt !== s0) begin n_fail++; $display("FAIL bypass_nostart got %0d starts want 0", start_cnt - s0); end
  endtask

  task automatic test_backpressure();
    bit acc, ok; int n_acc; logic [DW-1:0] r; logic [TGW-1:0] tg; logic e; exp_t x;
    n_acc = 0;
    OutReady = 1'b0;
    for (int i = 0; i < 6; i++) begin
      push_one(32'sd12 * (i + 1), -32'sd18, TGW'(i + 4), acc);
      if (acc) n_acc++;
      if (i == 5) begin
        n_checks++;
        if (acc) begin n_fail++; $display("FAIL bp_sixth got InReady=1 want 0"); end
      end
    end
    n_checks++;
    if (n_acc !== 5) begin n_fail++; $display("FAIL bp_accepted got %0d want 5", n_acc); end
    n_checks++;
    if (FifoLevel !== 3'd4) begin n_fail++; $display("FAIL bp_level got %0d want 4", FifoLevel); end
    for (int i = 0; i < 5; i++) begin
      collect(r, tg, e, ok);
      x = model_q.pop_front();
      n_checks++;
      if (!ok || r !== x.res || tg !== x.tag || e !== x.err) begin
        n_fail++;
        $display("FAIL bp_order[%0d] got ok=%b res=%0d tag=%0d err=%b want %0d %0d %b",
                 i, ok, r, tg, e, x.res, x.tag, x.err);
      end
    end
  endtask

  task automatic test_random();
    bit acc, ok; int k; logic [DW-1:0] r; logic [TGW-1:0] tg; logic e; exp_t x;
    for (int round = 0; round < 10; round++) begin
      k = $urandom_range(1, 5);
      for (int i = 0; i < k; i++) push_one(rand_op(), rand_op(), TGW'($urandom_range(0, 15)), acc);
      while (model_q.size() > 0) begin
        collect(r, tg, e, ok);
        x = model_q.pop_front();
        n_checks++;
        if (!ok || r !== x.res || tg !== x.tag || e !== x.err) begin
          n_fail++;
          $display("FAIL random[%0d] got ok=%b res=%0d tag=%0d err=%b want %0d %0d %b",
                   round, ok, r, tg, e, x.res, x.tag, x.err);
        end
      end
    end
  endtask

  task automatic test_reset_mid_run();
    bit acc, ok, seen; logic [DW-1:0] r; logic [TGW-1:0] tg; logic e; exp_t x; int s0;
    core_auto = 1'b0; done_man = 1'b0;
    push_one(32'sd100, 32'sd75, 4'd5, acc);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (CoreStart === 1'b1) seen = 1; else @(negedge Clk);
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL midrun_start got CoreStart=0 want 1"); end
    Reset = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    model_q.delete();
    n_checks++;
    if (CoreStart !== 1'b0 || FifoLevel !== 3'd0 || OutValid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_abort got CoreStart=%b FifoLevel=%0d OutValid=%b want 0 0 0",
               CoreStart, FifoLevel, OutValid);
    end
    @(negedge Clk);
    @(negedge Clk);
    done_man = 1'b1; res_man = 32'd25;
    s0 = start_cnt;
    push_one(32'sd12, -32'sd18, 4'd6, acc);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (FifoLevel !== 3'd1 || CoreStart !== 1'b0 || OutValid !== 1'b0) begin
        n_fail++;
        $display("FAIL midrun_hold[%0d] got FifoLevel=%0d CoreStart=%b OutValid=%b want 1 0 0",
                 i, FifoLevel, CoreStart, OutValid);
      end
      @(negedge Clk);
    end
    done_man = 1'b0; res_man = '0;
    core_auto = 1'b1;
    collect(r, tg, e, ok);
    x = model_q.pop_front();
    n_checks++;
    if (!ok || r !== x.res || tg !== x.tag || e !== x.err || start_cnt - s0 !== 1) begin
      n_fail++;
      $display("FAIL midrun_next got ok=%b res=%0d tag=%0d err=%b starts=%0d want %0d %0d %b 1",
               ok, r, tg, e, start_cnt - s0, x.res, x.tag, x.err);
    end
  endtask

`ifdef GCD_DISPATCH_TIMEOUT_EN
  task automatic test_timeout();
    bit acc, ok; logic [DW-1:0] r; logic [TGW-1:0] tg; logic e; exp_t x;
    core_auto = 1'b0; done_man = 1'b0;
    push_one(32'sd30, 32'sd45, 4'd2, acc);
    collect(r, tg, e, ok);
    x = model_q.pop_front();
    n_checks++;
    if (!ok || r !== '0 || e !== 1'b1 || tg !== x.tag) begin
      n_fail++;
      $display("FAIL timeout_result got ok=%b res=%0d tag=%0d err=%b want 0 %0d 1", ok, r, tg, e, x.tag);
    end
    core_auto = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_core_path(32'sd77777, 32'sd63, 4'd3, 32'd77777, 32'd63);
    test_core_path(-32'sd48, 32'sd18, 4'd1, 32'd48, 32'd18);
    test_bypass(32'sd0, -32'sd25, 4'd9);
    test_bypass(32'sd0, 32'sd0, 4'd7);
    test_bypass(32'sh8000_0000, 32'sd5, 4'd11);
    test_backpressure();
    test_random();
    test_reset_mid_run();
`ifdef GCD_DISPATCH_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gcd_req_dispatch.md
Name: gcd_req_dispatch

Overview:
- Upstream request stage for gcd_top.
- Accepts signed operand pairs with a tag over a valid/ready interface and buffers them in a small FIFO.
- Normalises signs to magnitudes and short-circuits trivial cases (zero operand, unrepresentable magnitude) without the core.
- Otherwise drives Start/A/B into gcd_top, captures Result on Done, and presents a tagged result on a valid/ready output.

Parameters:
- DATA_WIDTH, 32, operand/result width; must match gcd_top DATA_WIDTH.
- FIFO_DEPTH, 4, input FIFO entries; power of two, at least 2.
- TAG_WIDTH, 4, width of the user tag carried with each request.
- TIMEOUT_CYCLES, 1024, watchdog limit; used only with GCD_DISPATCH_TIMEOUT_EN.

Ports:
- Clk  in  1  clock; all logic on rising edge.
- Reset  in  1  synchronous, active-low reset.
- InValid  in  1  request valid.
- InReady  out  1  request accepted when InValid&InReady.
- InA  in  DATA_WIDTH  signed operand A.
- InB  in  DATA_WIDTH  signed operand B.
- InTag  in  TAG_WIDTH  request tag.
- CoreStart  out  1  to gcd_top Start.
- CoreA  out  DATA_WIDTH  to gcd_top A; magnitude, always >= 1.
- CoreB  out  DATA_WIDTH  to gcd_top B; magnitude, always >= 1.
- CoreResult  in  DATA_WIDTH  from gcd_top Result.
- CoreDone  in  1  from gcd_top Done; pulse or level.
- OutValid  out  1  result valid.
- OutReady  in  1  result consumed when OutValid&OutReady.
- OutResult  out  DATA_WIDTH  gcd, non-negative.
- OutTag  out  TAG_WIDTH  tag of the originating request.
- OutErr  out  1  result invalid (unrepresentable operand or timeout).
- FifoLevel  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (Reset=0 at a rising edge): FSM=IDLE; FIFO emptied; FifoLevel=0; InReady=0 during the reset cycle, then 1; CoreStart=0; CoreA=CoreB=0; OutValid=0; OutResult=0; OutTag=0; OutErr=0.
- Reset mid-operation aborts any in-flight request with no output. A CoreDone arriving afterwards is ignored by the IDLE rule below.
- FIFO:
  - InReady = !full.
  - Push on InValid&InReady.
  - Pop only in IDLE when non-empty and CoreDone=0.
  - Push and pop in the same cycle keeps the level unchanged.
  - An entry pushed at edge t is poppable at edge t+1.
- Normalisation, combinational on the FIFO head: |A|, |B| in DATA_WIDTH bits.
  - If either operand = -2^(DATA_WIDTH-1): error bypass.
  - Else if A=0 and B=0: result 0.
  - Else if A=0: result |B|.
  - Else if B=0: result |A|.
  - Else: core path.
- FSM states IDLE, RUN, DRAIN, OUT:
  - IDLE, bypass case: pop; load OutResult/OutTag/OutErr; OutValid=1 next cycle; go to OUT. Bypass latency = 2 cycles from push to OutValid when FIFO empty and FSM idle.
  - IDLE, core case: pop; register CoreA=|A|, CoreB=|B|, tag; CoreStart=1 next cycle; go to RUN.
  - RUN: CoreStart, CoreA, CoreB held stable. On the first cycle with CoreDone=1: capture CoreResult; CoreStart=0; go to DRAIN.
  - DRAIN: wait until CoreDone=0; then OutValid=1 with captured result, OutErr=0; go to OUT. A pulse-type Done costs one extra cycle.
  - OUT: hold OutValid/OutResult/OutTag/OutErr stable until OutReady=1. On that edge OutValid=0 and FSM goes to IDLE. The next pop can occur on the following edge, so at most one result per 2 cycles.
- CoreStart is never asserted outside RUN. Exactly one CoreStart assertion occurs per core-path request.
- FIFO keeps accepting while the FSM is busy. Backpressure: total buffering = FIFO_DEPTH + 1 (the request held in the FSM).

Optional Feature:
- Macro GCD_DISPATCH_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to RUN and increments each RUN cycle.
  - If it reaches TIMEOUT_CYCLES with no CoreDone: CoreStart=0; go to DRAIN; the result presented is OutResult=0, OutErr=1.
  - A CoreDone arriving on the same edge as the timeout takes priority (normal result).
- Not defined: no counter; RUN waits indefinitely; OutErr is set only by the unrepresentable-operand bypass.

Test Plan:
- Basic core path: push A=77777, B=63, tag 3 with a behavioural gcd model (Done after N cycles) -> one CoreStart assertion with CoreA=77777, CoreB=63; OutResult=7, OutTag=3, OutErr=0.
- Signs: push A=-48, B=18 -> CoreA=48, CoreB=18; OutResult=6, OutErr=0.
- Zero bypass: push A=0, B=-25, tag 9 into idle block -> CoreStart never rises; OutValid 2 cycles after push; OutResult=25, OutTag=9. A=0, B=0 -> OutResult=0, OutErr=0.
- Unrepresentable operand: push A=-2147483648, B=5 -> no CoreStart; OutResult=0, OutErr=1.
- Backpressure: OutReady=0, push 6 consecutive requests (FIFO_DEPTH=4) -> 5 accepted; InReady low from the 6th; FifoLevel=4. Release OutReady -> results emerge in push order with matching tags.
- Reset mid-RUN: drive Reset=0 for one cycle while CoreStart=1; core raises Done 3 cycles later -> CoreStart=0, FifoLevel=0, OutValid stays 0; next request pops only after CoreDone=0 and completes normally. With GCD_DISPATCH_TIMEOUT_EN and TIMEOUT_CYCLES=16, core never raises Done -> OutErr=1, OutResult=0.
